// File: rtl/hazard_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package hazard_pkg;
  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_LU  = 2'd1,
    ST_FRZ = 2'd2
  } hz_state_e;

  localparam int BR_ID    = 1;
  localparam int BR_EX    = 2;
  localparam int BR_MEM   = 3;
  localparam int REG_ZERO = 0;
  localparam int LAT_W    = 4;
endpackage

// File: rtl/hazard_match.sv
// rs/rt source comparator against a single writer register; $0 never matches.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              use_rs_i,
  input  logic              use_rt_i,
  input  logic [REG_AW-1:0] wreg_i,
  output logic              hit_o
);
  logic wnz;

  assign wnz   = (wreg_i != REG_AW'(REG_ZERO));
  assign hit_o = wnz && ((use_rs_i && (rs_i == wreg_i)) || (use_rt_i && (rt_i == wreg_i)));
endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Stall/flush controller: load-use FSM, branch/jump flushes, mem_busy freeze, event counters.
module hazard_ctrl_pipe
  import hazard_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int LOAD_LAT     = 1,
  parameter int FWD_EN       = 1,
  parameter int RF_WFIRST    = 1,
  parameter int BRANCH_STAGE = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic              mem_regwrite,
  input  logic              mem_memread,
  input  logic [REG_AW-1:0] mem_wreg,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_wreg,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_stall,
  output logic              exmem_stall,
  output logic              idex_bubble,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              flush_exmem,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  hz_state_e              state_q, state_d, saved_q, saved_d, cur;
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic                   ex_hit, mem_hit, wb_hit;
  logic                   lu_hz, br_hz, raw_hz, seq_hz, any_hz;
  logic                   pcs_c, ifs_c, ids_c, exs_c, bub_c, fif_c, fid_c, fex_c;

  hazard_match #(.REG_AW(REG_AW)) u_ex (
    .rs_i(id_rs), .rt_i(id_rt), .use_rs_i(id_use_rs), .use_rt_i(id_use_rt),
    .wreg_i(ex_wreg), .hit_o(ex_hit)
  );
  hazard_match #(.REG_AW(REG_AW)) u_mem (
    .rs_i(id_rs), .rt_i(id_rt), .use_rs_i(id_use_rs), .use_rt_i(id_use_rt),
    .wreg_i(mem_wreg), .hit_o(mem_hit)
  );
  hazard_match #(.REG_AW(REG_AW)) u_wb (
    .rs_i(id_rs), .rt_i(id_rt), .use_rs_i(id_use_rs), .use_rt_i(id_use_rt),
    .wreg_i(wb_wreg), .hit_o(wb_hit)
  );

  assign lu_hz  = ex_memread && ex_regwrite && ex_hit;
  assign br_hz  = (BRANCH_STAGE == BR_ID) && id_branch &&
                  ((ex_regwrite && ex_hit) || (mem_memread && mem_hit));
  assign raw_hz = (ex_regwrite && ex_hit) || (mem_regwrite && mem_hit) ||
                  ((RF_WFIRST == 0) && wb_regwrite && wb_hit);
  // Without forwarding a load keeps matching as it moves down, so no counted stall is needed.
  assign seq_hz = (FWD_EN != 0) && lu_hz;
  assign any_hz = ((FWD_EN != 0) ? lu_hz : raw_hz) || br_hz;
  assign cur    = (state_q == ST_FRZ) ? saved_q : state_q;

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    lat_d   = lat_q;
    pcs_c = 1'b0; ifs_c = 1'b0; ids_c = 1'b0; exs_c = 1'b0;
    bub_c = 1'b0; fif_c = 1'b0; fid_c = 1'b0; fex_c = 1'b0;
    if (mem_busy) begin
      pcs_c = 1'b1; ifs_c = 1'b1; ids_c = 1'b1; exs_c = 1'b1;
      state_d = ST_FRZ;
      if (state_q != ST_FRZ) saved_d = state_q;
    end else if (branch_taken) begin
      fif_c   = 1'b1;
      fid_c   = (BRANCH_STAGE >= BR_EX);
      fex_c   = (BRANCH_STAGE >= BR_MEM);
      state_d = ST_RUN;
      lat_d   = '0;
    end else if (cur == ST_LU) begin
      pcs_c = 1'b1; ifs_c = 1'b1; bub_c = 1'b1;
      if (lat_q <= LAT_W'(1)) begin
        state_d = ST_RUN;
        lat_d   = '0;
      end else begin
        state_d = ST_LU;
        lat_d   = lat_q - LAT_W'(1);
      end
    end else if (any_hz) begin
      pcs_c = 1'b1; ifs_c = 1'b1; bub_c = 1'b1;
      state_d = ST_RUN;
      if (seq_hz && (LOAD_LAT > 1)) begin
        state_d = ST_LU;
        lat_d   = LAT_W'(LOAD_LAT - 1);
      end
    end else begin
      state_d = ST_RUN;
      fif_c   = id_jump;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pcs_c && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((fif_c || fid_c || fex_c) && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      saved_q     <= ST_RUN;
      lat_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      lat_q       <= lat_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Controls are combinational, so reset must mask them directly.
  assign pc_stall    = !rst && pcs_c;
  assign ifid_stall  = !rst && ifs_c;
  assign idex_stall  = !rst && ids_c;
  assign exmem_stall = !rst && exs_c;
  assign idex_bubble = !rst && bub_c;
  assign flush_ifid  = !rst && fif_c;
  assign flush_idex  = !rst && fid_c;
  assign flush_exmem = !rst && fex_c;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Scoreboard bench: six configurations, expected controls/counters queued per driven cycle.
module tb_hazard_ctrl_pipe;
  localparam int NI = 6;
  localparam int LL [NI] = '{1, 3, 1, 1, 1, 1};
  localparam int FW [NI] = '{1, 1, 0, 0, 1, 1};
  localparam int WF [NI] = '{1, 1, 0, 1, 1, 1};
  localparam int BS [NI] = '{2, 2, 2, 2, 3, 1};
  localparam int CW [NI] = '{16, 4, 16, 16, 16, 16};

  // {pc, ifid, idex, exmem, bubble, flush_ifid, flush_idex, flush_exmem}
  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_LU   = 8'b1100_1000;
  localparam logic [7:0] C_FRZ  = 8'b1111_0000;
  localparam logic [7:0] C_FIF  = 8'b0000_0100;
  localparam logic [7:0] C_BR2  = 8'b0000_0110;
  localparam logic [7:0] C_BR3  = 8'b0000_0111;

  typedef struct packed {
    logic [4:0] rs, rt;
    logic       use_rs, use_rt, br, jmp, exw, exr;
    logic [4:0] exreg;
    logic       memw, memr;
    logic [4:0] memreg;
    logic       wbw;
    logic [4:0] wbreg;
    logic       bt, busy;
  } in_t;

  typedef struct {
    int         g;
    string      tag;
    logic [7:0] ctl;
    int         sc;
    int         fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  in_t         in_a  [NI];
  logic [7:0]  ctl_a [NI];
  logic [31:0] sc_a  [NI];
  logic [31:0] fc_a  [NI];
  exp_t        sb [$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [CW[g]-1:0] sc, fc;
    logic ps, ifs, ids, exs, bub, ff, fi, fe;
    hazard_ctrl_pipe #(
      .REG_AW(5), .LOAD_LAT(LL[g]), .FWD_EN(FW[g]), .RF_WFIRST(WF[g]),
      .BRANCH_STAGE(BS[g]), .CNT_W(CW[g])
    ) u_dut (
      .clk(clk), .rst(rst),
      .id_rs(in_a[g].rs), .id_rt(in_a[g].rt),
      .id_use_rs(in_a[g].use_rs), .id_use_rt(in_a[g].use_rt),
      .id_branch(in_a[g].br), .id_jump(in_a[g].jmp),
      .ex_regwrite(in_a[g].exw), .ex_memread(in_a[g].exr), .ex_wreg(in_a[g].exreg),
      .mem_regwrite(in_a[g].memw), .mem_memread(in_a[g].memr), .mem_wreg(in_a[g].memreg),
      .wb_regwrite(in_a[g].wbw), .wb_wreg(in_a[g].wbreg),
      .branch_taken(in_a[g].bt), .mem_busy(in_a[g].busy),
      .pc_stall(ps), .ifid_stall(ifs), .idex_stall(ids), .exmem_stall(exs),
      .idex_bubble(bub), .flush_ifid(ff), .flush_idex(fi), .flush_exmem(fe),
      .stall_cnt(sc), .flush_cnt(fc)
    );
    assign ctl_a[g] = {ps, ifs, ids, exs, bub, ff, fi, fe};
    assign sc_a[g]  = 32'(sc);
    assign fc_a[g]  = 32'(fc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      chk($sformatf("i%0d.%s.ctl", e.g, e.tag), 32'(ctl_a[e.g]), 32'(e.ctl));
      chk($sformatf("i%0d.%s.stall_cnt", e.g, e.tag), sc_a[e.g], e.sc);
      chk($sformatf("i%0d.%s.flush_cnt", e.g, e.tag), fc_a[e.g], e.fc);
    end
  end

  task automatic push(input int g, input string tag, input logic [7:0] ctl, input int sc, input int fc);
    exp_t e;
    e.g = g; e.tag = tag; e.ctl = ctl; e.sc = sc; e.fc = fc;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int g, input string tag, input logic [7:0] ctl, input int sc, input int fc);
    push(g, tag, ctl, sc, fc);
    tick();
  endtask

  task automatic clr(input int g);
    in_a[g] = '0;
  endtask

  task automatic ld_ex(input int g, input logic [4:0] w, input logic [4:0] s);
    in_a[g].exw = 1'b1; in_a[g].exr = 1'b1; in_a[g].exreg = w;
    in_a[g].rs = s; in_a[g].use_rs = 1'b1;
  endtask

  // ID reads $2 while the load sits in MEM and EX holds a bubble.
  task automatic ld_mem(input int g);
    clr(g);
    in_a[g].memw = 1'b1; in_a[g].memr = 1'b1; in_a[g].memreg = 5'd2;
    in_a[g].rs = 5'd2; in_a[g].use_rs = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < NI; g++) clr(g);
    ld_ex(0, 5'd2, 5'd2);
    tick();
    for (int g = 0; g < NI; g++) push(g, "reset", C_NONE, 0, 0);
    tick();
    rst = 1'b0;
    clr(0);

    // LOAD_LAT=1 with forwarding
    ld_ex(0, 5'd2, 5'd2); in_a[0].rt = 5'd4; in_a[0].use_rt = 1'b1;
    step(0, "lu1", C_LU, 0, 0);
    ld_mem(0);                                   step(0, "lu1_done", C_NONE, 1, 0);
    clr(0); in_a[0].jmp = 1'b1;                  step(0, "jump", C_FIF, 1, 0);
    clr(0); ld_ex(0, 5'd0, 5'd0);                step(0, "lw_r0", C_NONE, 1, 1);
    clr(0); in_a[0].exw = 1'b1; in_a[0].exreg = 5'd3; in_a[0].rs = 5'd3; in_a[0].use_rs = 1'b1;
    step(0, "alu_fwd", C_NONE, 1, 1);
    clr(0); ld_ex(0, 5'd2, 5'd2); in_a[0].bt = 1'b1;
    step(0, "br_over_lu", C_BR2, 1, 1);
    clr(0); in_a[0].busy = 1'b1; in_a[0].jmp = 1'b1;
    step(0, "busy_over_jmp", C_FRZ, 1, 2);
    clr(0);                                      step(0, "after_frz", C_NONE, 2, 2);

    // No forwarding, read-after-write regfile disabled
    in_a[2].wbw = 1'b1; in_a[2].wbreg = 5'd5; in_a[2].rs = 5'd5; in_a[2].use_rs = 1'b1;
    step(2, "wb_raw", C_LU, 0, 0);
    clr(2); in_a[2].exw = 1'b1; in_a[2].exreg = 5'd5; in_a[2].rs = 5'd5; in_a[2].use_rs = 1'b1;
    step(2, "ex_raw", C_LU, 1, 0);
    clr(2); in_a[2].memw = 1'b1; in_a[2].memreg = 5'd5; in_a[2].rs = 5'd5; in_a[2].use_rs = 1'b1;
    step(2, "mem_raw", C_LU, 2, 0);
    clr(2); in_a[2].wbw = 1'b1; in_a[2].wbreg = 5'd5; in_a[2].rt = 5'd5; in_a[2].rs = 5'd6;
    in_a[2].use_rs = 1'b1;
    step(2, "rt_unused", C_NONE, 3, 0);

    // No forwarding, write-first regfile
    in_a[3].wbw = 1'b1; in_a[3].wbreg = 5'd5; in_a[3].rs = 5'd5; in_a[3].use_rs = 1'b1;
    step(3, "wb_wfirst", C_NONE, 0, 0);
    clr(3); in_a[3].memw = 1'b1; in_a[3].memreg = 5'd5; in_a[3].rt = 5'd5; in_a[3].use_rt = 1'b1;
    step(3, "mem_raw", C_LU, 0, 0);
    clr(3);                                      step(3, "idle", C_NONE, 1, 0);

    // Branch resolved in MEM
    in_a[4].bt = 1'b1;                           step(4, "br_mem", C_BR3, 0, 0);
    clr(4);                                      step(4, "br_mem_after", C_NONE, 0, 1);

    // Branch resolved in ID
    in_a[5].br = 1'b1; in_a[5].rs = 5'd7; in_a[5].use_rs = 1'b1;
    in_a[5].exw = 1'b1; in_a[5].exreg = 5'd7;
    step(5, "bid_ex_alu", C_LU, 0, 0);
    clr(5); in_a[5].br = 1'b1; in_a[5].rs = 5'd7; in_a[5].use_rs = 1'b1;
    in_a[5].memw = 1'b1; in_a[5].memr = 1'b1; in_a[5].memreg = 5'd7;
    step(5, "bid_mem_load", C_LU, 1, 0);
    in_a[5].memr = 1'b0;                         step(5, "bid_mem_alu", C_NONE, 2, 0);
    clr(5); in_a[5].bt = 1'b1;                   step(5, "br_id", C_FIF, 2, 0);
    clr(5);                                      step(5, "br_id_after", C_NONE, 2, 1);

    // LOAD_LAT=3, 4-bit counters
    ld_ex(1, 5'd2, 5'd2);                        step(1, "lu3_c1", C_LU, 0, 0);
    ld_mem(1);                                   step(1, "lu3_c2", C_LU, 1, 0);
                                                 step(1, "lu3_c3", C_LU, 2, 0);
                                                 step(1, "lu3_end", C_NONE, 3, 0);
    clr(1); ld_ex(1, 5'd0, 5'd0);                step(1, "lu3_r0", C_NONE, 3, 0);
    clr(1); ld_ex(1, 5'd2, 5'd2);                step(1, "brlu_c1", C_LU, 3, 0);
    ld_mem(1); in_a[1].bt = 1'b1;                step(1, "brlu_c2", C_BR2, 4, 0);
    ld_mem(1);                                   step(1, "brlu_after", C_NONE, 4, 1);
    clr(1); ld_ex(1, 5'd2, 5'd2);                step(1, "frz_c1", C_LU, 4, 1);
    ld_mem(1);                                   step(1, "frz_c2", C_LU, 5, 1);
    in_a[1].busy = 1'b1;                         step(1, "frz_b1", C_FRZ, 6, 1);
    in_a[1].bt = 1'b1;                           step(1, "frz_b2_bt", C_FRZ, 7, 1);
    in_a[1].bt = 1'b0;                           step(1, "frz_b3", C_FRZ, 8, 1);
                                                 step(1, "frz_b4", C_FRZ, 9, 1);
    in_a[1].busy = 1'b0;                         step(1, "frz_resume", C_LU, 10, 1);
                                                 step(1, "frz_end", C_NONE, 11, 1);
    clr(1); in_a[1].busy = 1'b1;
    for (int k = 11; k <= 15; k++)               step(1, $sformatf("sat_%0d", k), C_FRZ, k, 1);
                                                 step(1, "sat_hold", C_FRZ, 15, 1);
    clr(1);                                      step(1, "sat_rel", C_NONE, 15, 1);
    ld_ex(1, 5'd2, 5'd2);                        step(1, "sat_lu1", C_LU, 15, 1);
    ld_mem(1);                                   step(1, "sat_lu2", C_LU, 15, 1);
    rst = 1'b1; ld_ex(1, 5'd2, 5'd2);            step(1, "rst_mid", C_NONE, 0, 0);
    rst = 1'b0; ld_mem(1);                       step(1, "rst_rel", C_NONE, 0, 0);

    tick();
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
